// File: rtl/lcd_pkg.sv
// Shared parameters, digit byte type and converter FSM states for the
// LCD digit pipeline.
package lcd_pkg;

    localparam int SUM_W_DEF   = 17;
    localparam int N_W_DEF     = 10;
    localparam int SUM_DIG_DEF = 5;
    localparam int N_DIG_DEF   = 3;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef logic [7:0] digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic longint unsigned pow10(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/sum_bcd_converter_core.sv
// Double-dabble core: converts a W-bit operand into DIG BCD nibbles, one bit
// per enabled cycle. Digits beyond DIG fall off the top, giving modulo 10^DIG.
module bcd_dd_core #(
    parameter int W   = 17,
    parameter int DIG = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic [W-1:0]     operand_i,
    output logic [4*DIG-1:0] bcd_o
);

    logic [W-1:0]     op_q, op_d;
    logic [4*DIG-1:0] bcd_q, bcd_d;
    logic [4*DIG-1:0] adj;

    always_comb begin
        adj   = bcd_q;
        op_d  = op_q;
        bcd_d = bcd_q;
        for (int i = 0; i < DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        if (load_i) begin
            op_d  = operand_i;
            bcd_d = '0;
        end else if (shift_en_i) begin
            bcd_d = {adj[4*DIG-2:0], op_q[W-1]};
            op_d  = op_q << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            bcd_q <= '0;
        end else begin
            op_q  <= op_d;
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/sum_bcd_converter.sv
// Converts a binary sum and term count into LCD digit bytes.
// Define SUM_BCD_SAT_EN to saturate out-of-range values to all nines.
module sum_bcd_converter
    import lcd_pkg::*;
#(
    parameter int SUM_W   = SUM_W_DEF,
    parameter int N_W     = N_W_DEF,
    parameter int SUM_DIG = SUM_DIG_DEF,
    parameter int N_DIG   = N_DIG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [SUM_W-1:0] sum_i,
    input  logic [N_W-1:0]   n_i,
    output digit_t           data_o   [SUM_DIG],
    output digit_t           data_N_o [N_DIG],
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(SUM_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SUM_W);
    // N finishes early: it shifts only while the counter is above this mark.
    localparam logic [CNT_W-1:0] N_STOP   = CNT_W'(SUM_W - N_W);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load;
    logic               shiftSum;
    logic               shiftN;
    logic [4*SUM_DIG-1:0] sumBcd, sumFinal, sumNib_q;
    logic [4*N_DIG-1:0]   nBcd, nFinal, nNib_q;
    logic               done_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        shiftSum = 1'b0;
        shiftN   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shiftSum = 1'b1;
                shiftN   = (cnt_q > N_STOP);
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    bcd_dd_core #(
        .W   (SUM_W),
        .DIG (SUM_DIG)
    ) u_sum_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .shift_en_i (shiftSum),
        .operand_i  (sum_i),
        .bcd_o      (sumBcd)
    );

    bcd_dd_core #(
        .W   (N_W),
        .DIG (N_DIG)
    ) u_n_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .shift_en_i (shiftN),
        .operand_i  (n_i),
        .bcd_o      (nBcd)
    );

`ifdef SUM_BCD_SAT_EN
    logic sumOvf_q, nOvf_q;

    // Range is judged on the captured operands, not on the truncated BCD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumOvf_q <= 1'b0;
            nOvf_q   <= 1'b0;
        end else if (load) begin
            sumOvf_q <= (64'(sum_i) >= pow10(SUM_DIG));
            nOvf_q   <= (64'(n_i) >= pow10(N_DIG));
        end
    end

    assign sumFinal = sumOvf_q ? {SUM_DIG{4'h9}} : sumBcd;
    assign nFinal   = nOvf_q   ? {N_DIG{4'h9}}   : nBcd;
`else
    assign sumFinal = sumBcd;
    assign nFinal   = nBcd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumNib_q <= '0;
            nNib_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (state_q == DONE) begin
                sumNib_q <= sumFinal;
                nNib_q   <= nFinal;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SUM_DIG; i++) begin
            data_o[i] = {4'h0, sumNib_q[4*i +: 4]};
        end
        for (int i = 0; i < N_DIG; i++) begin
            data_N_o[i] = {4'h0, nNib_q[4*i +: 4]};
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Scoreboard bench for sum_bcd_converter: driver pushes expected digits on
// each accepted start, a negedge monitor checks results, latency and busy.
module tb_sum_bcd_converter;

    localparam int SUM_W   = 17;
    localparam int N_W     = 10;
    localparam int SUM_DIG = 5;
    localparam int N_DIG   = 3;

    typedef struct {
        logic [8*SUM_DIG-1:0] s;
        logic [8*N_DIG-1:0]   n;
        int                   acc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [SUM_W-1:0] sum_i;
    logic [N_W-1:0]   n_i;
    logic [7:0]       dataO  [SUM_DIG];
    logic [7:0]       dataNO [N_DIG];
    logic             busyO;
    logic             doneO;

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    exp_t scoreQ[$];
    int   busyFrom   = 0;
    bit   busyActive = 0;
    logic [8*SUM_DIG-1:0] lastSum = '0;
    logic [8*N_DIG-1:0]   lastN   = '0;

    sum_bcd_converter #(
        .SUM_W   (SUM_W),
        .N_W     (N_W),
        .SUM_DIG (SUM_DIG),
        .N_DIG   (N_DIG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .sum_i    (sum_i),
        .n_i      (n_i),
        .data_o   (dataO),
        .data_N_o (dataNO),
        .busy_o   (busyO),
        .done_o   (doneO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: decimal digits by plain division, one byte per digit.
    function automatic logic [63:0] modelDigits(input longint unsigned v, input int dig);
        logic [63:0]     r;
        longint unsigned lim;
        longint unsigned x;
        lim = 1;
        for (int i = 0; i < dig; i++) lim = lim * 10;
        r = '0;
        x = v % lim;
`ifdef SUM_BCD_SAT_EN
        if (v >= lim) x = lim - 1;
`endif
        for (int i = 0; i < dig; i++) begin
            r[8*i +: 8] = 8'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [8*SUM_DIG-1:0] actualSum();
        logic [8*SUM_DIG-1:0] r;
        for (int i = 0; i < SUM_DIG; i++) r[8*i +: 8] = dataO[i];
        return r;
    endfunction

    function automatic logic [8*N_DIG-1:0] actualN();
        logic [8*N_DIG-1:0] r;
        for (int i = 0; i < N_DIG; i++) r[8*i +: 8] = dataNO[i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExpected(input longint unsigned s, input longint unsigned n);
        exp_t e;
        e.s   = modelDigits(s, SUM_DIG)[8*SUM_DIG-1:0];
        e.n   = modelDigits(n, N_DIG)[8*N_DIG-1:0];
        e.acc = cyc;
        scoreQ.push_back(e);
        busyFrom   = cyc;
        busyActive = 1'b1;
    endtask

    // Issues one start pulse; the caller guarantees the DUT is idle.
    task automatic applyStimulus(input longint unsigned s, input longint unsigned n);
        @(negedge clk);
        start_i = 1'b1;
        sum_i   = SUM_W'(s);
        n_i     = N_W'(n);
        @(posedge clk);
        #1;
        pushExpected(s, n);
        start_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("busy", 64'(busyO), 64'(busyActive && (cyc <= busyFrom + SUM_W)));
            if (doneO) begin
                if (scoreQ.size() == 0) begin
                    checkOutput("unexpected_done", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = scoreQ.pop_front();
                    checkOutput("latency", 64'(cyc - e.acc), 64'(SUM_W + 1));
                    checkOutput("sum_digits", 64'(actualSum()), 64'(e.s));
                    checkOutput("n_digits", 64'(actualN()), 64'(e.n));
                    lastSum = e.s;
                    lastN   = e.n;
                end
            end else begin
                checkOutput("hold_sum", 64'(actualSum()), 64'(lastSum));
                checkOutput("hold_n", 64'(actualN()), 64'(lastN));
            end
        end
    end

    initial begin
        rst_n   = 1'b1;
        start_i = 1'b0;
        sum_i   = '0;
        n_i     = '0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_busy", 64'(busyO), 64'(0));
        checkOutput("reset_done", 64'(doneO), 64'(0));
        checkOutput("reset_sum", 64'(actualSum()), 64'(0));
        checkOutput("reset_n", 64'(actualN()), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, starting on the first edge after reset release.
        applyStimulus(12345, 157);
        repeat (20) @(posedge clk);
        applyStimulus(0, 0);
        repeat (20) @(posedge clk);
        applyStimulus(131071, 1023);
        repeat (20) @(posedge clk);
        applyStimulus(99999, 999);
        repeat (20) @(posedge clk);
        applyStimulus(100000, 1000);
        repeat (20) @(posedge clk);

        // A second start during a conversion must be ignored.
        applyStimulus(24680, 864);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start_i = 1'b1;
        sum_i   = 1;
        n_i     = 1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (20) @(posedge clk);

        // Asynchronous reset in the middle of a conversion.
        applyStimulus(54321, 321);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        scoreQ.delete();
        busyActive = 1'b0;
        lastSum    = '0;
        lastN      = '0;
        checkOutput("midreset_busy", 64'(busyO), 64'(0));
        checkOutput("midreset_done", 64'(doneO), 64'(0));
        checkOutput("midreset_sum", 64'(actualSum()), 64'(0));
        checkOutput("midreset_n", 64'(actualN()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        applyStimulus(54321, 321);
        repeat (20) @(posedge clk);

        // start_i held high: a new conversion every SUM_W+2 cycles.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start_i = 1'b1;
            sum_i   = SUM_W'($urandom_range(0, (1 << SUM_W) - 1));
            n_i     = N_W'($urandom_range(0, (1 << N_W) - 1));
            @(posedge clk);
            #1;
            pushExpected(longint'(sum_i), longint'(n_i));
            repeat (SUM_W + 1) @(posedge clk);
        end
        @(negedge clk);
        start_i = 1'b0;
        repeat (20) @(posedge clk);

        // Randomized operands with random idle gaps.
        for (int k = 0; k < 25; k++) begin
            applyStimulus($urandom_range(0, (1 << SUM_W) - 1), $urandom_range(0, (1 << N_W) - 1));
            repeat (SUM_W + 1 + $urandom_range(0, 3)) @(posedge clk);
        end

        repeat (25) @(posedge clk);
        checkOutput("scoreboard_drained", 64'(scoreQ.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sum_bcd_converter.md
SUM_BCD_CONVERTER -- requirements
Module: sum_bcd_converter

Interface
REQ-001 SHALL have parameter SUM_W, default 17, binary width of the cumulative sum input.
REQ-002 SHALL have parameter N_W, default 10, binary width of the term-count input.
REQ-003 SHALL have parameter SUM_DIG, default 5, number of decimal digits produced for the sum.
REQ-004 SHALL have parameter N_DIG, default 3, number of decimal digits produced for N.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start_i  input  1  request conversion of sum_i and n_i.
REQ-008 SHALL have port sum_i  input  SUM_W  binary cumulative sum.
REQ-009 SHALL have port n_i  input  N_W  binary term count.
REQ-010 SHALL have port data_o  output  [7:0] x SUM_DIG (unpacked, index 0 = units)  sum digits, each 0..9, feeding the LCD driver's data_i.
REQ-011 SHALL have port data_N_o  output  [7:0] x N_DIG (unpacked, index 0 = units)  N digits, each 0..9, feeding the LCD driver's data_N_i.
REQ-012 SHALL have port busy_o  output  1  conversion in progress.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse when new digits are valid.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: start_i=1 SHALL capture sum_i and n_i, clear BCD scratch registers, load shift counter with SUM_W, go to SHIFT.
REQ-016 SHIFT: each cycle SHALL apply add-3 to every BCD nibble >=5, then shift left one bit, MSB of operand entering nibble 0; counter decrements.
REQ-017 N conversion SHALL run in parallel and freeze after N_W shifts; the sum conversion sets overall length of SUM_W cycles.
REQ-018 SHIFT SHALL go to DONE when counter reaches 0; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-019 Latency: start_i sampled at edge k -> data_o/data_N_o updated and done_o=1 in cycle following edge k+SUM_W+1.
REQ-020 busy_o SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-021 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-022 start_i held high SHALL restart a conversion on the first IDLE cycle after DONE.
REQ-023 data_o/data_N_o SHALL hold last converted values between done_o pulses; intermediate scratch values never visible.
REQ-024 Each output byte SHALL be {4'h0, BCD nibble}; upper nibble always zero.
REQ-025 Sum digits above SUM_DIG SHALL be discarded (result modulo 10^SUM_DIG) unless REQ-030 applies; N digits likewise modulo 10^N_DIG.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, counter 0, all data_o/data_N_o bytes 8'h00, busy_o=0, done_o=0.
REQ-027 Reset mid-SHIFT SHALL abort conversion; outputs show zeros, no done_o after release.
REQ-028 First start_i accepted on first rising edge with rst_n=1.

Configuration
REQ-029 Macro SUM_BCD_SAT_EN SHALL select overflow handling.
REQ-030 Defined: captured sum >= 10^SUM_DIG SHALL output all sum digits = 9 (e.g. 99999); N >= 10^N_DIG likewise all 9; undefined: modulo behaviour of REQ-025.

Structure
REQ-031 Package lcd_pkg SHALL hold SUM_W/N_W/SUM_DIG/N_DIG defaults, ASCII_ZERO = 8'h30, digit byte typedef, FSM state enum.
REQ-032 Sub-module bcd_dd_core (parameterized width/digits, shift-enable input) SHALL be instantiated twice, one for sum, one for N; FSM and counter stay in top.

Verification
REQ-033 sum_i=12345, n_i=157, start pulse -> after 18 cycles done_o=1, data_o={1,2,3,4,5} (MSB..units), data_N_o={1,5,7}.
REQ-034 sum_i=0, n_i=0 -> all digits 0, done_o one cycle, busy_o high exactly 18 cycles.
REQ-035 sum_i=131071, n_i=1023: without macro data_o={3,1,0,7,1}, data_N_o={0,2,3}; with SUM_BCD_SAT_EN data_o={9,9,9,9,9}, data_N_o={9,9,9}.
REQ-036 start_i pulsed again at cycle 5 of conversion with sum_i=1 -> ignored; result reflects first operands.
REQ-037 rst_n low at cycle 8 of conversion of 54321 -> outputs 0, busy_o=0, no done_o; next start converts 54321 correctly.
REQ-038 start_i held high continuously -> done_o every 19 cycles, outputs track sum_i.
